uart_seq_trig: RTL and testbench
================================

# uart_seq_trig

Parametrised UART protocol trigger for the logic-analyzer capture path: receives serial frames on one analyzer channel and asserts a capture trigger when a programmed sequence of SEQ_LEN consecutive data words matches per-word mask/match patterns. It generalises the single-byte UART protocol trigger in data width and sequence depth, and adds an arm enable, framing-error detection, and a sticky, clearable trigger. Its output feeds the trigger combiner alongside the SPI protocol trigger.

## Interface
- DATA_W, 8: data bits per frame, legal 5..9.
- SEQ_LEN, 4: words in the match sequence, legal 1..8.
- BAUD_W, 16: width of the baud-count input.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  raw asynchronous serial line (analyzer channel); idle high.
- baud_cnt  in  BAUD_W  clocks per bit; legal values ≥ 4; latched at start detect.
- mask  in  SEQ_LEN*DATA_W  per-word mask, word k at [k*DATA_W +: DATA_W]; bit=1 means don't care.
- match  in  SEQ_LEN*DATA_W  per-word match value, same packing.
- en  in  1  arm; when low the matcher is held idle and no trigger is set.
- clr_trig  in  1  single-cycle clear of trig.
- trig  out  1  sticky trigger level.
- rx_vld  out  1  one-cycle pulse: rx_data holds a good frame.
- rx_data  out  DATA_W  last good received word.
- frm_err  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- rx passes through a 2-flop synchroniser; both flops reset to 1.
- Receiver FSM states and transitions:
  - IDLE: latch baud_cnt into B on a synchronised 1→0 transition, then go to START.
  - START: wait H = B>>1 clocks, then sample. If low, go to DATA. If high, treat it as a false start: return to IDLE with no outputs.
  - DATA: sample DATA_W bits, one every B clocks, LSB first, into a shift register.
  - STOP: sample once after B more clocks. High → pulse rx_vld and update rx_data. Low → pulse frm_err; the word is discarded. In both cases return to IDLE.
- Matcher: index idx in 0..SEQ_LEN-1, reset 0. It acts only on rx_vld with en=1. Word k matches when (rx_data & ~mask_k) == (match_k & ~mask_k).
  - Match at idx, and idx = SEQ_LEN-1: set trig, idx←0.
  - Match at idx otherwise: idx←idx+1.
  - Mismatch: idx←1 if the word matches word 0, else 0. Restart is single-level only; no deeper overlap search.
- frm_err, or en=0, forces idx←0.
- There is no inter-word timeout: words need not be back-to-back in time.
- trig stays at 1 until clr_trig. If clr_trig and a set occur in the same cycle, trig stays 1, so the event is not lost.
- Changes to mask/match take effect on the next rx_vld. Changes to baud_cnt mid-frame are ignored.
- Reset values: trig=0, rx_vld=0, frm_err=0, rx_data=0, idx=0, FSM=IDLE.
- Reset mid-frame aborts the frame with no pulses. Reception resumes only after rx goes high, then falls again.

## Timing
- Cycle 0 is the first cycle the synchroniser output is 0 while in IDLE. The pin-to-cycle-0 delay is 2 clocks.
- Sample schedule:
  - start sample at cycle H;
  - data bit i (0-based) at H+(i+1)·B;
  - stop sample at H+(DATA_W+1)·B.
- rx_vld, rx_data, frm_err and a newly set trig are all registered. They are visible in the cycle after the stop sample, i.e. cycle H+(DATA_W+1)·B+1.
- IDLE accepts a new start in the cycle after the stop sample. A back-to-back frame with a one-bit stop is received without loss.
- clr_trig takes effect on the next clock edge.

## Structure
- Package uart_seq_trig_pkg holds:
  - the receiver state enum (IDLE, START, DATA, STOP);
  - the mask-polarity note (1 = don't care);
  - localparams for legal DATA_W/SEQ_LEN bounds, with elaboration-time assertions.
- Sub-module uart_rx_core contains the synchroniser, baud counter, bit counter and FSM. Its outputs are rx_vld, rx_data and frm_err.
- The matcher and trig register live in the top level.

## Test plan
- Single match: DATA_W=8, SEQ_LEN=1, baud_cnt=16, mask=0, match=0xA5; send 0xA5 → trig=1 at cycle H+9·16+1 = 153 after detect. Sending 0xA4 instead → trig stays 0.
- Sequence with restart: SEQ_LEN=3, pattern 0x12,0x34,0x56; send 0x12,0x12,0x34,0x56 → trig set after the 4th frame, not earlier.
- Don't-care and width: DATA_W=9, mask word0=0x0FF, match=0x100; send 0x1C3 → match; send 0x0C3 → no match.
- Framing error: pattern 0x55,0xAA; send 0x55, then 0xAA with the stop bit low → frm_err pulse, no rx_vld for that frame, idx=0. Sending 0xAA again → no trig.
- Arm and clear: with en=0, send a matching sequence → trig=0. Raise en and resend → trig=1. Pulse clr_trig on the same cycle as a new set → trig remains 1; an isolated clr_trig → trig=0 next cycle.
- False start and reset: a 3-clock low glitch on rx with baud_cnt=16 → no outputs, FSM returns to IDLE. Asserting rst mid-frame → all outputs 0, and the following frame is received correctly.

Source files
------------

// File: rtl/uart_seq_trig_pkg.sv
// Shared types, legal parameter bounds and the word-compare helper for the
// UART sequence trigger.
package uart_seq_trig_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Mask polarity: a mask bit of 1 marks that data bit as don't care.
    localparam logic MASK_DONT_CARE = 1'b1;

    localparam int DATA_W_MIN  = 5;
    localparam int DATA_W_MAX  = 9;
    localparam int SEQ_LEN_MIN = 1;
    localparam int SEQ_LEN_MAX = 8;

    // Compare one word against a mask/match pair; callers zero-extend to DATA_W_MAX.
    function automatic logic word_hit(input logic [DATA_W_MAX-1:0] data,
                                      input logic [DATA_W_MAX-1:0] mask,
                                      input logic [DATA_W_MAX-1:0] value);
        logic [DATA_W_MAX-1:0] care;
        care = (MASK_DONT_CARE == 1'b1) ? ~mask : mask;
        return ((data ^ value) & care) == '0;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, baud down-counter, bit counter and FSM.
// good_o/bad_o/word_o are the unregistered stop-sample results so the matcher
// can register its outcome in the same edge as rx_vld_o.
//
// state   | meaning
// IDLE    | waiting for a synchronised 1->0 transition
// START   | counting half a bit, then checking the start bit is still low
// DATA    | sampling DATA_W bits, LSB first, one per bit period
// STOP    | counting one bit, then sampling the stop bit
module uart_rx_core
    import uart_seq_trig_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BAUD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic [BAUD_W-1:0] baud_cnt_i,
    output logic              good_o,
    output logic              bad_o,
    output logic [DATA_W-1:0] word_o,
    output logic              rx_vld_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              frm_err_o
);

    localparam int BC_W = $clog2(DATA_W);

    logic              sync1_q, sync2_q, prev_q;
    logic [1:0]        flush_q;
    logic              fall;
    rx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] b_q, b_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              vld_q, err_q;
    logic [DATA_W-1:0] data_q;
    logic              good, bad;

    // Synchroniser plus line history; prev_q stays low until a genuine post-reset
    // high has been seen, so a line held low through reset never looks like a start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            flush_q <= 2'b00;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            flush_q <= {flush_q[0], 1'b1};
            prev_q  <= sync2_q & flush_q[1];
        end
    end

    assign fall = prev_q & ~sync2_q;

    // FSM, baud/bit counters and shift register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; every sample happens when the down-counter reaches zero.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        good    = 1'b0;
        bad     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    b_d     = baud_cnt_i;
                    cnt_d   = (baud_cnt_i >> 1) - BAUD_W'(1);
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - BAUD_W'(1);
                end else if (!sync2_q) begin
                    cnt_d   = b_q - BAUD_W'(1);
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - BAUD_W'(1);
                end else begin
                    shift_d = {sync2_q, shift_q[DATA_W-1:1]};
                    cnt_d   = b_q - BAUD_W'(1);
                    if (bit_q == BC_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - BAUD_W'(1);
                end else begin
                    good    = sync2_q;
                    bad     = ~sync2_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered frame outputs; rx_data only moves on a good frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q <= good;
            err_q <= bad;
            if (good) begin
                data_q <= shift_q;
            end
        end
    end

    assign good_o    = good;
    assign bad_o     = bad;
    assign word_o    = shift_q;
    assign rx_vld_o  = vld_q;
    assign rx_data_o = data_q;
    assign frm_err_o = err_q;

endmodule

// File: rtl/uart_seq_trig.sv
// UART protocol trigger: fires a sticky trig when SEQ_LEN consecutive good
// words match their per-word mask/match patterns.
module uart_seq_trig
    import uart_seq_trig_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SEQ_LEN = 4,
    parameter int BAUD_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic [BAUD_W-1:0]         baud_cnt,
    input  logic [SEQ_LEN*DATA_W-1:0] mask,
    input  logic [SEQ_LEN*DATA_W-1:0] match,
    input  logic                      en,
    input  logic                      clr_trig,
    output logic                      trig,
    output logic                      rx_vld,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      frm_err
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_seq_trig: DATA_W out of range");
    end
    if (SEQ_LEN < SEQ_LEN_MIN || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_seq_len
        $error("uart_seq_trig: SEQ_LEN out of range");
    end

    logic              good, bad;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              trig_q, trig_d;
    logic [DATA_W-1:0] mask_cur, match_cur;
    logic              hit_cur, hit_0, last;

    uart_rx_core #(
        .DATA_W (DATA_W),
        .BAUD_W (BAUD_W)
    ) u_rx (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_i       (rx),
        .baud_cnt_i (baud_cnt),
        .good_o     (good),
        .bad_o      (bad),
        .word_o     (word),
        .rx_vld_o   (rx_vld),
        .rx_data_o  (rx_data),
        .frm_err_o  (frm_err)
    );

    // Compare the completed word against the expected entry and against entry 0.
    always_comb begin
        mask_cur  = mask[int'(idx_q)*DATA_W +: DATA_W];
        match_cur = match[int'(idx_q)*DATA_W +: DATA_W];
        hit_cur   = word_hit(DATA_W_MAX'(word), DATA_W_MAX'(mask_cur), DATA_W_MAX'(match_cur));
        hit_0     = word_hit(DATA_W_MAX'(word), DATA_W_MAX'(mask[DATA_W-1:0]),
                             DATA_W_MAX'(match[DATA_W-1:0]));
        last      = (idx_q == IDX_W'(SEQ_LEN - 1));
    end

    // Sequence index and sticky trigger; a set wins over a simultaneous clear.
    always_comb begin
        idx_d  = idx_q;
        trig_d = trig_q;
        if (clr_trig) begin
            trig_d = 1'b0;
        end
        if (!en || bad) begin
            idx_d = '0;
        end else if (good) begin
            if (hit_cur) begin
                if (last) begin
                    trig_d = 1'b1;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else if (hit_0 && SEQ_LEN > 1) begin
                idx_d = IDX_W'(1);
            end else begin
                idx_d = '0;
            end
        end
    end

    // Matcher registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            trig_q <= trig_d;
        end
    end

    assign trig = trig_q;

endmodule

// File: tb/tb_uart_seq_trig.sv
// Directed bench: instance A (8-bit words, 3-word sequence) and instance B
// (9-bit words, single word), both at 16 clocks per bit.
module tb_uart_seq_trig;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_a, rx_b;
    logic        en, clr_trig;
    logic [15:0] baud;
    logic [23:0] mask_a, match_a;
    logic [8:0]  mask_b, match_b;
    logic        trig_a, rx_vld_a, frm_err_a;
    logic [7:0]  rx_data_a;
    logic        trig_b, rx_vld_b, frm_err_b;
    logic [8:0]  rx_data_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int frame_t0 = 0;
    int vld_a_cnt = 0, err_a_cnt = 0, vld_b_cnt = 0;
    int vld_a_cyc = -1, trig_a_cyc = -1, trig_b_cyc = -1;
    logic trig_a_prev = 1'b0, trig_b_prev = 1'b0;
    int snap_vld, snap_err;

    uart_seq_trig #(.DATA_W(8), .SEQ_LEN(3), .BAUD_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .baud_cnt(baud), .mask(mask_a), .match(match_a),
        .en(en), .clr_trig(clr_trig), .trig(trig_a), .rx_vld(rx_vld_a),
        .rx_data(rx_data_a), .frm_err(frm_err_a)
    );

    uart_seq_trig #(.DATA_W(9), .SEQ_LEN(1), .BAUD_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .baud_cnt(baud), .mask(mask_b), .match(match_b),
        .en(en), .clr_trig(clr_trig), .trig(trig_b), .rx_vld(rx_vld_b),
        .rx_data(rx_data_b), .frm_err(frm_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_vld_a) begin
            vld_a_cnt++;
            vld_a_cyc = cyc;
        end
        if (frm_err_a) err_a_cnt++;
        if (rx_vld_b) vld_b_cnt++;
        if (trig_a && !trig_a_prev) trig_a_cyc = cyc;
        if (trig_b && !trig_b_prev) trig_b_cyc = cyc;
        trig_a_prev = trig_a;
        trig_b_prev = trig_b;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // Called just after a rising edge; leaves the line idle high afterwards.
    task automatic send(input bit sel, input logic [8:0] d, input int nb, input logic stopv);
        frame_t0 = cyc;
        line(sel, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            line(sel, d[i]);
            repeat (16) @(posedge clk);
            #1;
        end
        line(sel, stopv);
        repeat (16) @(posedge clk);
        #1;
        line(sel, 1'b1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_trig = 1'b1;
        @(posedge clk);
        #1;
        clr_trig = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_a     = 1'b1;
        rx_b     = 1'b1;
        en       = 1'b1;
        clr_trig = 1'b0;
        baud     = 16'd16;
        mask_a   = 24'h000000;
        match_a  = {8'h56, 8'h34, 8'h12};
        mask_b   = 9'h000;
        match_b  = 9'h0A5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        check("rst_trig_a", trig_a, 0);
        check("rst_vld_a", rx_vld_a, 0);
        check("rst_err_a", frm_err_a, 0);
        check("rst_data_a", rx_data_a, 0);
        check("rst_trig_b", trig_b, 0);
        check("rst_data_b", rx_data_b, 0);

        // Sequence with single-level restart: 12,12,34,56.
        send(0, 9'h012, 8, 1'b1);
        check("vld_latency", vld_a_cyc - frame_t0, 155);
        check("seq_data0", rx_data_a, 8'h12);
        check("seq_trig0", trig_a, 0);
        send(0, 9'h012, 8, 1'b1);
        check("seq_trig1", trig_a, 0);
        send(0, 9'h034, 8, 1'b1);
        check("seq_trig2", trig_a, 0);
        send(0, 9'h056, 8, 1'b1);
        check("seq_trig3", trig_a, 1);
        check("trig_latency", trig_a_cyc - frame_t0, 155);
        check("seq_vld_cnt", vld_a_cnt, 4);

        pulse_clr();
        check("clr_iso_a", trig_a, 0);

        // Clear coincident with a new set: set wins.
        send(0, 9'h012, 8, 1'b1);
        send(0, 9'h034, 8, 1'b1);
        fork
            send(0, 9'h056, 8, 1'b1);
            begin
                wait (cyc == frame_t0 + 154);
                #1;
                clr_trig = 1'b1;
                @(posedge clk);
                #1;
                clr_trig = 1'b0;
            end
        join
        check("clr_set_same", trig_a, 1);
        pulse_clr();
        check("clr_iso_b", trig_a, 0);

        // Framing error resets the index and discards the word.
        send(0, 9'h012, 8, 1'b1);
        snap_vld = vld_a_cnt;
        send(0, 9'h034, 8, 1'b0);
        check("frm_err_cnt", err_a_cnt, 1);
        check("frm_no_vld", vld_a_cnt, snap_vld);
        check("frm_data_kept", rx_data_a, 8'h12);
        send(0, 9'h034, 8, 1'b1);
        send(0, 9'h056, 8, 1'b1);
        check("frm_no_trig", trig_a, 0);

        // Disarmed: no trigger.
        en = 1'b0;
        send(0, 9'h012, 8, 1'b1);
        send(0, 9'h034, 8, 1'b1);
        send(0, 9'h056, 8, 1'b1);
        check("en0_no_trig", trig_a, 0);
        check("en0_data", rx_data_a, 8'h56);
        en = 1'b1;
        send(0, 9'h012, 8, 1'b1);
        send(0, 9'h034, 8, 1'b1);
        send(0, 9'h056, 8, 1'b1);
        check("en1_trig", trig_a, 1);
        pulse_clr();
        // Dropping en between words forgets the partial sequence.
        send(0, 9'h012, 8, 1'b1);
        send(0, 9'h034, 8, 1'b1);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        send(0, 9'h056, 8, 1'b1);
        check("en_drop_idx", trig_a, 0);

        // False start: a 3-clock glitch produces nothing.
        snap_vld = vld_a_cnt;
        snap_err = err_a_cnt;
        rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_no_vld", vld_a_cnt, snap_vld);
        check("glitch_no_err", err_a_cnt, snap_err);
        send(0, 9'h077, 8, 1'b1);
        check("glitch_next_data", rx_data_a, 8'h77);
        check("glitch_next_vld", vld_a_cnt, snap_vld + 1);

        // Instance B: single 9-bit word, exact and don't-care matching.
        send(1, 9'h0A4, 9, 1'b1);
        check("b_no_trig", trig_b, 0);
        check("b_data_a4", rx_data_b, 9'h0A4);
        send(1, 9'h0A5, 9, 1'b1);
        check("b_trig", trig_b, 1);
        check("b_trig_latency", trig_b_cyc - frame_t0, 171);
        pulse_clr();
        check("b_clr", trig_b, 0);
        mask_b  = 9'h0FF;
        match_b = 9'h100;
        send(1, 9'h0C3, 9, 1'b1);
        check("b_dc_miss", trig_b, 0);
        send(1, 9'h1C3, 9, 1'b1);
        check("b_dc_hit", trig_b, 1);
        check("b_data_9bit", rx_data_b, 9'h1C3);
        check("b_vld_cnt", vld_b_cnt, 4);

        // Reset mid-frame, with the line still low when reset releases.
        send(0, 9'h012, 8, 1'b1);
        send(0, 9'h034, 8, 1'b1);
        send(0, 9'h056, 8, 1'b1);
        check("pre_rst_trig", trig_a, 1);
        rx_a = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_trig_a", trig_a, 0);
        check("rst_mid_trig_b", trig_b, 0);
        check("rst_mid_vld", rx_vld_a, 0);
        check("rst_mid_err", frm_err_a, 0);
        check("rst_mid_data", rx_data_a, 0);
        snap_vld = vld_a_cnt;
        snap_err = err_a_cnt;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("rst_low_no_vld", vld_a_cnt, snap_vld);
        check("rst_low_no_err", err_a_cnt, snap_err);
        rx_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(0, 9'h05A, 8, 1'b1);
        check("post_rst_data", rx_data_a, 8'h5A);
        check("post_rst_vld", vld_a_cnt, snap_vld + 1);
        check("post_rst_err", err_a_cnt, snap_err);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
